tdc_report_tx: RTL and testbench

TDC_REPORT_TX -- requirements
Module: tdc_report_tx

---
 rtl/tdc_report_tx.sv | 195 +++++++++++++++++++
 tb/tb_tdc_report_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_report_tx.sv
`default_nettype none
// ============================================================================
// Module   : tdc_report_tx
// Purpose  : Serialises 32-bit TDC measurements into 6-byte UART 8N1 frames:
//            HEADER, meas[31:24], meas[23:16], meas[15:8], meas[7:0], checksum
//            (checksum = XOR of the four data bytes). One measurement can wait
//            in a holding register while a frame is in flight; newer strobes
//            overwrite it and are counted as drops.
// Ports    : clk          - system clock, rising-edge
//            reset        - asynchronous, active-high
//            meas_valid   - one-cycle strobe, meas_cycles valid
//            meas_cycles  - 32-bit measured cycle count
//            tx           - UART serial line (idle high, registered)
//            busy         - frame in transmission
//            pending      - a measurement waits in the holding register
//            drop_count   - saturating count of overwritten measurements
// Revision : 1.0 - initial release
// ============================================================================
module tdc_report_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        meas_valid,
  input  logic [31:0] meas_cycles,
  output logic        tx,
  output logic        busy,
  output logic        pending,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE = 3'd5;

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [2:0]  byte_idx, byte_idx_n;
  logic [31:0] word, word_n;
  logic [7:0]  csum, csum_n;
  logic [7:0]  shreg, shreg_n;
  logic [31:0] hold, hold_n;
  logic        pending_n;
  logic [7:0]  drop_n;
  logic        tx_n;

  logic        baud_done;
  logic        launch;
  logic [31:0] launch_word;
  logic [7:0]  next_byte;

  assign baud_done   = (baud_cnt == BAUD_LAST);
  // A waiting word always goes out before a word arriving in the same cycle.
  assign launch_word = pending ? hold : meas_cycles;
  assign busy        = (state != IDLE);

  // Byte that follows the one currently on the line.
  always_comb begin
    next_byte = csum;
    case (byte_idx)
      3'd0:    next_byte = word[31:24];
      3'd1:    next_byte = word[23:16];
      3'd2:    next_byte = word[15:8];
      3'd3:    next_byte = word[7:0];
      default: next_byte = csum;
    endcase
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    word_n     = word;
    csum_n     = csum;
    shreg_n    = shreg;
    hold_n     = hold;
    pending_n  = pending;
    drop_n     = drop_count;
    tx_n       = tx;
    launch     = 1'b0;

    case (state)
      IDLE: begin
        if (meas_valid || pending) launch = 1'b1;
      end
      START: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
          tx_n       = shreg[0];
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          if (byte_idx != LAST_BYTE) begin
            byte_idx_n = byte_idx + 3'd1;
            shreg_n    = next_byte;
            state_n    = START;
            tx_n       = 1'b0;
          end else if (meas_valid || pending) begin
            // Chain straight into the next frame with no idle bit time.
            launch = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    if (launch) begin
      state_n    = START;
      baud_cnt_n = '0;
      bit_idx_n  = '0;
      byte_idx_n = '0;
      word_n     = launch_word;
      csum_n     = launch_word[31:24] ^ launch_word[23:16] ^
                   launch_word[15:8]  ^ launch_word[7:0];
      shreg_n    = HEADER;
      tx_n       = 1'b0;
      // If the held word is being launched, a simultaneous strobe replaces it
      // in the holding register without counting as a drop.
      pending_n  = pending & meas_valid;
      if (pending && meas_valid) hold_n = meas_cycles;
    end else if (meas_valid && (state != IDLE)) begin
      hold_n    = meas_cycles;
      pending_n = 1'b1;
      if (pending && (drop_count != 8'hFF)) drop_n = drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      word       <= '0;
      csum       <= '0;
      shreg      <= '0;
      hold       <= '0;
      pending    <= 1'b0;
      drop_count <= '0;
      tx         <= 1'b1;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_idx    <= bit_idx_n;
      byte_idx   <= byte_idx_n;
      word       <= word_n;
      csum       <= csum_n;
      shreg      <= shreg_n;
      hold       <= hold_n;
      pending    <= pending_n;
      drop_count <= drop_n;
      tx         <= tx_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdc_report_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_report_tx
// Purpose  : Directed self-checking bench for tdc_report_tx (CLKS_PER_BIT=4).
//            Decodes the serial line cycle by cycle and compares frames,
//            bit timing, inter-byte gaps and status outputs with
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_report_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        meas_valid = 1'b0;
  logic [31:0] meas_cycles = '0;
  logic        tx;
  logic        busy;
  logic        pending;
  logic [7:0]  drop_count;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int busy_cnt = 0;

  tdc_report_tx #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) dut (
    .clk         (clk),
    .reset       (reset),
    .meas_valid  (meas_valid),
    .meas_cycles (meas_cycles),
    .tx          (tx),
    .busy        (busy),
    .pending     (pending),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy === 1'b1) busy_cnt++;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns on the negedge just after the accepting edge.
  task automatic send(input logic [31:0] v);
    @(negedge clk);
    busy_cnt    = 0;
    meas_valid  = 1'b1;
    meas_cycles = v;
    @(negedge clk);
    meas_valid  = 1'b0;
    meas_cycles = 32'hDEAD_BEEF;
  endtask

  // Samples tx on every negedge: 4 samples per bit, all must agree.
  task automatic rx_byte(output logic [7:0] b, output int wait_cyc,
                         output bit stable, output bit ok);
    wait_cyc = 0;
    stable   = 1'b1;
    ok       = 1'b1;
    b        = '0;
    while (tx !== 1'b0) begin
      if (wait_cyc >= 2000) begin
        ok = 1'b0;
        return;
      end
      @(negedge clk);
      wait_cyc++;
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (tx !== 1'b0) stable = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b[i] = tx;
      for (int k = 1; k < 4; k++) begin
        @(negedge clk);
        if (tx !== b[i]) stable = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) stable = 1'b0;
    end
  endtask

  // first_wait: polls before the first start bit (0 = already low on call).
  // Following bytes must start on the very next cycle (one poll).
  task automatic rx_frame(output logic [47:0] f, input int first_wait);
    logic [7:0] b;
    int         w;
    bit         st;
    bit         ok;
    f = '0;
    for (int j = 0; j < 6; j++) begin
      rx_byte(b, w, st, ok);
      if (!ok) begin
        check("rx_timeout", 48'd0, 48'd1);
        return;
      end
      f = {f[39:0], b};
      check("bit_hold", 48'(st), 48'd1);
      check("byte_gap", 48'(w), (j == 0) ? 48'(first_wait) : 48'd1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || pending !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 48'(busy | pending), 48'd0);
  endtask

  initial begin
    logic [47:0] f1;
    logic [47:0] f2;

    // Reset and idle line
    repeat (3) @(negedge clk);
    check("rst_tx", 48'(tx), 48'd1);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_tx", 48'(tx), 48'd1);
      check("idle_busy", 48'(busy), 48'd0);
      check("idle_pend", 48'(pending), 48'd0);
      check("idle_drop", 48'(drop_count), 48'd0);
    end

    // Single frame, 1-cycle latency, busy width
    send(32'h0000_0006);
    rx_frame(f1, 0);
    check("frame_06", f1, 48'hA5_00_00_00_06_06);
    repeat (3) @(negedge clk);
    check("busy_len", 48'(busy_cnt), 48'd240);
    check("busy_end", 48'(busy), 48'd0);

    // Mixed data bytes
    send(32'h1234_5678);
    rx_frame(f1, 0);
    check("frame_1234", f1, 48'hA5_12_34_56_78_08);
    repeat (3) @(negedge clk);

    // Measurement queued mid-frame, back-to-back frames
    send(32'h0000_0006);
    fork
      begin
        rx_frame(f1, 0);
        rx_frame(f2, 1);
      end
      begin
        repeat (50) @(negedge clk);
        send(32'h0000_000A);
        check("pend_set", 48'(pending), 48'd1);
      end
    join
    check("chain_f1", f1, 48'hA5_00_00_00_06_06);
    check("chain_f2", f2, 48'hA5_00_00_00_0A_0A);
    check("chain_drop", 48'(drop_count), 48'd0);
    repeat (3) @(negedge clk);
    check("chain_pend", 48'(pending), 48'd0);

    // Overwrite of pending word
    send(32'h0000_0001);
    fork
      begin
        rx_frame(f1, 0);
        rx_frame(f2, 1);
      end
      begin
        repeat (30) @(negedge clk);
        send(32'h0000_0002);
        repeat (30) @(negedge clk);
        send(32'h0000_0003);
        check("ovw_drop", 48'(drop_count), 48'd1);
      end
    join
    check("ovw_f1", f1, 48'hA5_00_00_00_01_01);
    check("ovw_f3", f2, 48'hA5_00_00_00_03_03);
    repeat (3) @(negedge clk);
    check("ovw_busy", 48'(busy), 48'd0);

    // Saturation: 300 consecutive strobes
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      meas_valid  = 1'b1;
      meas_cycles = 32'(i);
    end
    @(negedge clk);
    meas_valid = 1'b0;
    check("drop_sat", 48'(drop_count), 48'd255);
    wait_idle("sat_drain");
    check("drop_hold", 48'(drop_count), 48'd255);

    // Asynchronous reset during byte 2
    send(32'h1122_3344);
    repeat (80) @(negedge clk);
    check("b2_start", 48'(tx), 48'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_tx", 48'(tx), 48'd1);
    check("arst_busy", 48'(busy), 48'd0);
    check("arst_pend", 48'(pending), 48'd0);
    check("arst_drop", 48'(drop_count), 48'd0);
    @(negedge clk);
    check("rst_hold_tx", 48'(tx), 48'd1);
    reset       = 1'b0;
    busy_cnt    = 0;
    meas_valid  = 1'b1;
    meas_cycles = 32'h0BAD_F00D;
    @(negedge clk);
    meas_valid  = 1'b0;
    rx_frame(f1, 0);
    check("post_rst", f1, 48'hA5_0B_AD_F0_0D_5B);
    repeat (3) @(negedge clk);
    check("post_busy", 48'(busy_cnt), 48'd240);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
